// File: rtl/cmp_sched_pkg.sv
// Shared types and helpers for the round-robin comparator scheduler.
package cmp_sched_pkg;

  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned CNTW_DEF = 16;
  localparam logic [CNTW_DEF-1:0] N_DONE_SAT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0]         last,
                                         input int unsigned        n_req);
    logic [3:0] w;
    int         idx;
    w = last;
    // Scan far-to-near so the closest set bit after last is the one that sticks.
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= int'(n_req)) begin
        idx = (int'(last) + k) % int'(n_req);
        if (req[idx]) w = idx[3:0];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational ripple subtractor X + ~Y + 1 with N/Z/C/V flags.
module cmp_core #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         v,
  output logic         n,
  output logic         z
);

  logic cy;
  logic cy_msb_in;
  logic yb;

  always_comb begin
    s         = '0;
    cy        = 1'b1;
    cy_msb_in = 1'b0;
    yb        = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      yb   = ~y[i];
      s[i] = x[i] ^ yb ^ cy;
      if (i == int'(W) - 1) cy_msb_in = cy;
      cy   = (x[i] & yb) | (cy & (x[i] ^ yb));
    end
  end

  assign c_out = cy;
  assign v     = cy ^ cy_msb_in;
  assign n     = s[W-1];
  assign z     = (s == '0);

endmodule

// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one magnitude comparator among N_REQ requesters.
module cmp_rr_sched
  import cmp_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned CNTW  = CNTW_DEF,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               done,
  output logic [IDW-1:0]     done_id,
  output logic               eq,
  output logic               lt_s,
  output logic               lt_u,
  output logic               ovf,
  output logic [CNTW-1:0]    n_done
);

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] id;
  logic [IDW-1:0] win;
  logic [W-1:0]   op_x;
  logic [W-1:0]   op_y;

  logic [W-1:0]   unused_diff;
  logic           cmp_c, cmp_v, cmp_n, cmp_z;

  assign win  = IDW'(rr_pick(MAX_REQ'(req), 4'(last), N_REQ));
  assign busy = (state != IDLE);

  // Only the flags are needed; the raw difference is left unused.
  cmp_core #(
    .W(W)
  ) u_core (
    .x    (op_x),
    .y    (op_y),
    .s    (unused_diff),
    .c_out(cmp_c),
    .v    (cmp_v),
    .n    (cmp_n),
    .z    (cmp_z)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      last    <= IDW'(N_REQ - 1);
      id      <= '0;
      op_x    <= '0;
      op_y    <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      eq      <= 1'b0;
      lt_s    <= 1'b0;
      lt_u    <= 1'b0;
      ovf     <= 1'b0;
      n_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            op_x  <= a_in[win*W +: W];
            op_y  <= b_in[win*W +: W];
            gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            id    <= win;
            last  <= win;
            state <= CMP;
          end
        end
        CMP: begin
          eq      <= cmp_z;
          lt_s    <= cmp_n ^ cmp_v;
          lt_u    <= ~cmp_c;
          ovf     <= cmp_v;
          done_id <= id;
          done    <= 1'b1;
          gnt     <= '0;
          state   <= RESP;
        end
        RESP: begin
          done  <= 1'b0;
          if (n_done != {CNTW{1'b1}}) n_done <= n_done + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_rr_sched.sv
// Self-checking bench for cmp_rr_sched: directed corners plus randomized arbitration.
module tb_cmp_rr_sched;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int CNTW = 10;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            Clock;
  logic            Resetn;
  logic [N-1:0]    req;
  logic [N*W-1:0]  a_in;
  logic [N*W-1:0]  b_in;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            done;
  logic [1:0]      done_id;
  logic            eq, lt_s, lt_u, ovf;
  logic [CNTW-1:0] n_done;

  int n_assert = 0;
  int n_fail   = 0;
  int last_m;
  int cnt_m;

  cmp_rr_sched #(
    .N_REQ(N),
    .W    (W),
    .CNTW (CNTW)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .done_id(done_id),
    .eq     (eq),
    .lt_s   (lt_s),
    .lt_u   (lt_u),
    .ovf    (ovf),
    .n_done (n_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first pending requester after the last winner, cyclically.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    a_in[i*W +: W] = x;
    b_in[i*W +: W] = y;
  endtask

  task automatic new_operands(input int i);
    logic [31:0] x, y;
    case ($urandom_range(0, 5))
      0:       x = 32'h8000_0000;
      1:       x = 32'h7FFF_FFFF;
      2:       x = 32'h0;
      default: x = $urandom;
    endcase
    y = ($urandom_range(0, 3) == 0) ? x : $urandom;
    set_op(i, x, y);
  endtask

  // One full transaction: caller has req set and is one ns past an edge with the DUT idle.
  task automatic run_op(input string tag);
    int          w;
    logic [31:0] xa, xb;
    longint      sa, sb, d, wr;
    logic        e_eq, e_lts, e_ltu, e_ovf;
    w = pick(req, last_m);
    if (w < 0) begin
      chk({tag, "_no_req"}, 64'(req), 64'(1));
      return;
    end
    xa    = a_in[w*W +: W];
    xb    = b_in[w*W +: W];
    sa    = longint'($signed(xa));
    sb    = longint'($signed(xb));
    d     = sa - sb;
    wr    = longint'($signed(xa - xb));
    e_ovf = (d != wr);
    e_lts = (sa < sb);
    e_ltu = (xa < xb);
    e_eq  = (xa == xb);

    @(posedge Clock); #1;
    chk({tag, "_gnt"}, 64'(gnt), 64'(4'b0001 << w));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_done_early"}, 64'(done), 64'(0));
    last_m = w;
    req[w] = 1'b0;
    // Scribble the winner's operands: result must come from the latched pair.
    new_operands(w);

    @(posedge Clock); #1;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_gnt_off"}, 64'(gnt), 64'(0));
    chk({tag, "_done_id"}, 64'(done_id), 64'(w));
    chk({tag, "_flags"}, 64'({eq, lt_s, lt_u, ovf}), 64'({e_eq, e_lts, e_ltu, e_ovf}));

    @(posedge Clock); #1;
    cnt_m = (cnt_m < CMAX) ? cnt_m + 1 : cnt_m;
    chk({tag, "_done_fall"}, 64'(done), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    chk({tag, "_n_done"}, 64'(n_done), 64'(cnt_m));
    chk({tag, "_hold"}, 64'({eq, lt_s, lt_u, ovf, done_id}),
        64'({e_eq, e_lts, e_ltu, e_ovf, 2'(w)}));
  endtask

  initial begin
    Resetn = 1'b0;
    req    = '0;
    a_in   = '0;
    b_in   = '0;
    last_m = N - 1;
    cnt_m  = 0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_busy_done", 64'({busy, done}), 64'(0));
    chk("rst_flags", 64'({eq, lt_s, lt_u, ovf, done_id}), 64'(0));
    chk("rst_n_done", 64'(n_done), 64'(0));
    Resetn = 1'b1;
    @(posedge Clock); #1;
    chk("idle_no_req", 64'({busy, gnt}), 64'(0));

    // Directed single-requester cases.
    set_op(0, 32'd5, 32'd9);                  req = 4'b0001; run_op("d_5_9");
    set_op(0, 32'hFFFF_FFFF, 32'h1);          req = 4'b0001; run_op("d_neg1_1");
    set_op(0, 32'h1234_5678, 32'h1234_5678);  req = 4'b0001; run_op("d_equal");
    set_op(0, 32'h8000_0000, 32'h1);          req = 4'b0001; run_op("d_ovf_neg");
    set_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);  req = 4'b0001; run_op("d_ovf_pos");

    // Reset during CMP: no done pulse, everything back to reset values.
    set_op(0, 32'd1, 32'd2);
    req = 4'b0001;
    @(posedge Clock); #1;
    chk("mid_gnt", 64'(gnt), 64'(1));
    Resetn = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'(0));
    chk("mid_rst_state", 64'({busy, done}), 64'(0));
    chk("mid_rst_flags", 64'({eq, lt_s, lt_u, ovf, done_id}), 64'(0));
    chk("mid_rst_n_done", 64'(n_done), 64'(0));
    req = '0;
    @(posedge Clock); #1;
    chk("mid_rst_no_done", 64'(done), 64'(0));
    Resetn = 1'b1;
    last_m = N - 1;
    cnt_m  = 0;

    // All four request together: strict order 0,1,2,3 at one op per 3 cycles.
    for (int i = 0; i < N; i++) set_op(i, 32'(i * 7), 32'(20 - i * 5));
    req = 4'b1111;
    for (int i = 0; i < N; i++) run_op($sformatf("rr%0d", i));
    chk("rr_last", 64'(last_m), 64'(N - 1));

    // Random traffic, long enough to drive n_done into saturation.
    for (int i = 0; i < N; i++) new_operands(i);
    for (int it = 0; it < CMAX + 20; it++) begin
      req = req | 4'($urandom);
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      run_op("rnd");
    end
    chk("sat_final", 64'(n_done), 64'(CMAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
